x_rd_arbiter: RTL and testbench

- Shares the single X-matrix SRAM read port among HEADER_NUM attention heads.
- Today only head 0 drives the port; this block sits between all heads and the X SRAM.
- Arbitration is round-robin, one SRAM read per cycle.
- Read data goes back to the granted head(s) with a valid strobe after a fixed pipeline latency.

---
 rtl/x_rd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_x_rd_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_rd_arbiter.sv
// x_rd_arbiter: shares the single X-matrix SRAM read port among HEADER_NUM
// attention heads. Round-robin, one SRAM read per cycle. Read data returns
// to the granted head(s) RD_LAT+1 cycles after the grant.
// Optional feature macro: X_ARB_MERGE_EN (same-address request merging).
module x_rd_arbiter #(
  parameter int HEADER_NUM = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 4,
  parameter int ADDR_W     = 13,
  parameter int RD_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_ok,
  output logic                           x_ren,
  output logic                           x_cs,
  output logic [ADDR_W-1:0]              x_rd_addr,
  input  logic [DATA_NUM*DATA_WIDTH-1:0] x,
  input  logic [HEADER_NUM-1:0]          head_req,
  input  logic [HEADER_NUM*ADDR_W-1:0]   head_addr,
  output logic [HEADER_NUM-1:0]          head_gnt,
  output logic [HEADER_NUM-1:0]          head_rvld,
  output logic [DATA_NUM*DATA_WIDTH-1:0] head_rdata,
  output logic                           busy
);

  localparam int PW = (HEADER_NUM > 1) ? $clog2(HEADER_NUM) : 1;

  typedef enum logic {
    WAIT_OK = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_next;
  logic [ADDR_W-1:0]     addr_arr [HEADER_NUM];
  logic [PW:0]           cand_sum;
  logic [PW-1:0]         cand;
  logic                  win_found;
  logic [PW-1:0]         win;
  logic [ADDR_W-1:0]     win_addr;
  logic [HEADER_NUM-1:0] win_onehot;
  logic [HEADER_NUM-1:0] gnt_vec;
  logic                  grant_en;
  logic [HEADER_NUM-1:0] pipe [RD_LAT];
  logic [HEADER_NUM-1:0] pipe_out;
  logic                  pipe_busy;

  // Unpack the flat per-head address bus and build the winner one-hot.
  for (genvar gi = 0; gi < HEADER_NUM; gi++) begin : g_head
    assign addr_arr[gi]   = head_addr[gi*ADDR_W +: ADDR_W];
    assign win_onehot[gi] = (win == PW'(gi));
  end

  // Round-robin search starting at ptr, wrapping modulo HEADER_NUM.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < HEADER_NUM; k++) begin
      cand_sum = {1'b0, ptr} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(HEADER_NUM)) begin
        cand_sum = cand_sum - (PW+1)'(HEADER_NUM);
      end
      cand = cand_sum[PW-1:0];
      if (!win_found && head_req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  assign win_addr = addr_arr[win];

`ifdef X_ARB_MERGE_EN
  logic [HEADER_NUM-1:0] same_addr;
  // Every requester asking for the winner's word rides on the same SRAM read.
  for (genvar gi = 0; gi < HEADER_NUM; gi++) begin : g_merge
    assign same_addr[gi] = head_req[gi] && (addr_arr[gi] == win_addr);
  end
  assign gnt_vec = win_onehot | same_addr;
`else
  assign gnt_vec = win_onehot;
`endif

  // A grant only happens in RUN while the SRAM is still readable.
  assign grant_en = (state == RUN) && x_ok && win_found;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_OK;
    else        state <= state_next;
  end

  // Next-state logic: follow x_ok.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_OK: if (x_ok)  state_next = RUN;
      RUN:     if (!x_ok) state_next = WAIT_OK;
      default:            state_next = WAIT_OK;
    endcase
  end

  // Output logic: grant and SRAM strobes in the same cycle as the request.
  always_comb begin
    head_gnt  = '0;
    x_ren     = 1'b0;
    x_cs      = 1'b0;
    x_rd_addr = '0;
    if (grant_en) begin
      head_gnt  = gnt_vec;
      x_ren     = 1'b1;
      x_cs      = 1'b1;
      x_rd_addr = win_addr;
    end
  end

  // Pointer moves just past the round-robin winner; holds otherwise.
  always_comb begin
    ptr_next = ptr;
    if (grant_en) begin
      ptr_next = (win == PW'(HEADER_NUM-1)) ? '0 : win + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_next;
  end

  // Grant vectors ride a shift pipe matching the SRAM read latency.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pipe[gi] <= '0;
      else if (gi == 0) pipe[gi] <= head_gnt;
      else              pipe[gi] <= pipe[(gi == 0) ? 0 : gi-1];
    end
  end

  assign pipe_out = pipe[RD_LAT-1];

  // Any non-zero stage means a read is still in flight.
  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < RD_LAT; s++) begin
      pipe_busy = pipe_busy | (|pipe[s]);
    end
  end

  // Capture SRAM data as the matching grant leaves the pipe; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_rvld  <= '0;
      head_rdata <= '0;
    end else begin
      head_rvld <= pipe_out;
      if (|pipe_out) head_rdata <= x;
    end
  end

  assign busy = pipe_busy | (x_ok & (|head_req));

endmodule

// File: tb/tb_x_rd_arbiter.sv
// Scoreboard bench for x_rd_arbiter: grants are checked in the stimulus
// process, and each expected read return is queued for the rvld monitor.
`timescale 1ns/1ps
module tb_x_rd_arbiter;

  localparam int HN = 8;
  localparam int DW = 16;
  localparam int DN = 4;
  localparam int AW = 13;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              x_ok = 1'b0;
  logic              x_ren;
  logic              x_cs;
  logic [AW-1:0]     x_rd_addr;
  logic [DN*DW-1:0]  x = '0;
  logic [HN-1:0]     head_req = '0;
  logic [HN*AW-1:0]  head_addr = '0;
  logic [HN-1:0]     head_gnt;
  logic [HN-1:0]     head_rvld;
  logic [DN*DW-1:0]  head_rdata;
  logic              busy;

  x_rd_arbiter #(
    .HEADER_NUM(HN), .DATA_WIDTH(DW), .DATA_NUM(DN), .ADDR_W(AW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_ok(x_ok), .x_ren(x_ren), .x_cs(x_cs),
    .x_rd_addr(x_rd_addr), .x(x), .head_req(head_req), .head_addr(head_addr),
    .head_gnt(head_gnt), .head_rvld(head_rvld), .head_rdata(head_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HN-1:0]    vec;
    logic [DN*DW-1:0] data;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic [AW-1:0] a_tab [HN];

  // Fixed contents of the X SRAM as a function of address.
  function automatic logic [DN*DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [15:0] w;
    w = {3'b000, a};
    return {w ^ 16'hA5A5, w + 16'h1234, ~w, {w[14:0], 1'b1}};
  endfunction

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (x_ren) x <= mem_word(x_rd_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // rvld monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (head_rvld != '0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rvld: got vec %b required none", head_rvld);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rvld_vec", 64'(head_rvld), 64'(mon_e.vec));
        chk("rvld_data", head_rdata, mon_e.data);
        chk("rvld_cycle", 64'(cyc), 64'(mon_e.cyc));
        $display("rvld cyc=%0d vec=%b data=%h", cyc, head_rvld, head_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    head_addr[i*AW +: AW] = a;
    a_tab[i] = a;
  endtask

  // Check the grant-cycle outputs; optionally queue the read return.
  task automatic expect_gnt(input logic [HN-1:0] vec, input logic [AW-1:0] a, input bit push);
    @(negedge clk);
    chk("gnt", 64'(head_gnt), 64'(vec));
    chk("x_ren", 64'(x_ren), 64'(vec != '0));
    if (vec != '0) begin
      chk("x_cs", 64'(x_cs), 64'(1));
      chk("x_rd_addr", 64'(x_rd_addr), 64'(a));
      if (push) sb_q.push_back('{vec: vec, data: mem_word(a), cyc: cyc + RL + 1});
    end
    $display("gnt cyc=%0d vec=%b addr=%h", cyc, head_gnt, x_rd_addr);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left required 0", sb_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    x_ok = 1'b0;
    head_req = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HN-1:0] v;

    // 1: no grants while x_ok=0, then first grant to head 0.
    reset_dut();
    for (int i = 0; i < HN; i++) set_addr(i, AW'(13'h100 + i * 7));
    head_req = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_gnt", 64'(head_gnt), 64'(0));
      chk("idle_x_ren", 64'(x_ren), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_rdata", head_rdata, 64'(0));
    end
    step();
    x_ok = 1'b1;
    expect_gnt(8'h00, '0, 1'b0);
    chk("busy_req", 64'(busy), 64'(1));
    step();
    expect_gnt(8'h01, a_tab[0], 1'b1);
    step();
    head_req = '0;
    drain();
    chk("rdata_hold", head_rdata, mem_word(a_tab[0]));
    chk("rvld_pulse", 64'(head_rvld), 64'(0));

    // 2: all heads request -> 0..7,0 back to back.
    reset_dut();
    x_ok = 1'b1;
    head_req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      v = 8'h01 << (k % 8);
      expect_gnt(v, a_tab[k % 8], 1'b1);
      chk("busy_run", 64'(busy), 64'(1));
      step();
    end
    head_req = '0;
    drain();

    // 3: pointer at 2, only head 5 requests; pointer then sits at 6.
    reset_dut();
    x_ok = 1'b1;
    head_req = 8'h02;
    step();
    expect_gnt(8'h02, a_tab[1], 1'b1);
    step();
    set_addr(5, 13'h1ABC);
    head_req = 8'h20;
    expect_gnt(8'h20, 13'h1ABC, 1'b1);
    step();
    head_req = 8'hA1;
    expect_gnt(8'h80, a_tab[7], 1'b1);
    step();
    head_req = 8'h21;
    expect_gnt(8'h01, a_tab[0], 1'b1);
    step();
    head_req = 8'h20;
    expect_gnt(8'h20, 13'h1ABC, 1'b1);
    step();
    head_req = '0;
    drain();

    // 4: x_ok falls with reads in flight.
    reset_dut();
    for (int i = 0; i < HN; i++) set_addr(i, AW'(13'h0A00 + i * 33));
    x_ok = 1'b1;
    head_req = 8'h1F;
    step();
    for (int k = 0; k < 4; k++) begin
      v = 8'h01 << k;
      expect_gnt(v, a_tab[k], 1'b1);
      step();
    end
    x_ok = 1'b0;
    head_req = 8'h10;
    @(negedge clk);
    chk("okdrop_gnt0", 64'(head_gnt), 64'(0));
    chk("okdrop_ren0", 64'(x_ren), 64'(0));
    chk("okdrop_busy0", 64'(busy), 64'(1));
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      chk("okdrop_gnt", 64'(head_gnt), 64'(0));
      chk("okdrop_busy", 64'(busy), 64'(0));
    end
    head_req = '0;
    drain();

    // 5: reset with two reads in flight discards them.
    reset_dut();
    x_ok = 1'b1;
    head_req = 8'h07;
    step();
    expect_gnt(8'h01, a_tab[0], 1'b1);
    step();
    head_req = 8'h06;
    expect_gnt(8'h02, a_tab[1], 1'b0);
    step();
    head_req = 8'h04;
    expect_gnt(8'h04, a_tab[2], 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 64'(head_gnt), 64'(0));
    chk("rst_x_ren", 64'(x_ren), 64'(0));
    chk("rst_x_rd_addr", 64'(x_rd_addr), 64'(0));
    chk("rst_rvld", 64'(head_rvld), 64'(0));
    chk("rst_rdata", head_rdata, 64'(0));
    head_req = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_rvld", 64'(head_rvld), 64'(0));
    end
    drain();

    // 6: heads 1 and 3 ask for the same word.
    reset_dut();
    set_addr(1, 13'h0040);
    set_addr(3, 13'h0040);
    x_ok = 1'b1;
    head_req = 8'h0A;
    step();
`ifdef X_ARB_MERGE_EN
    expect_gnt(8'h0A, 13'h0040, 1'b1);
    step();
    head_req = '0;
    expect_gnt(8'h00, '0, 1'b0);
`else
    expect_gnt(8'h02, 13'h0040, 1'b1);
    step();
    head_req = 8'h08;
    expect_gnt(8'h08, 13'h0040, 1'b1);
    step();
    head_req = '0;
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
